// File: rtl/flash_pkg.sv
// Shared flash definitions: command opcodes, loader state encoding and default word geometry.
package flash_pkg;
  localparam int WORD_BITS_DEF     = 8;
  localparam int ADDRESS_WORDS_DEF = 2;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_TRANSFER,
    ST_DONE,
    ST_ERROR
  } t_loader_state;
endpackage

// File: rtl/timeout_timer.sv
// Cycle counter with clear/enable; tc is high on the enabled cycle that reaches MAX_COUNT-1.
module timeout_timer #(
  parameter int MAX_COUNT = 4096
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge in_clk) begin
    if (!in_rst)         cnt <= '0;
    else if (clr || tc)  cnt <= '0;
    else if (en)         cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/flash_loader.sv
// Boot copy engine: one flash read burst streamed into a RAM write port.
// Define FLASH_LOADER_CHECKSUM_EN to build the running word checksum.
module flash_loader
  import flash_pkg::*;
#(
  parameter int          WORD_BITS        = WORD_BITS_DEF,
  parameter int          ADDRESS_WORDS    = ADDRESS_WORDS_DEF,
  parameter int          RAM_ADDR_BITS    = 10,
  parameter int          NUM_WORDS        = 256,
  parameter int unsigned FLASH_START_ADDR = 0,
  parameter int          TIMEOUT_CYCLES   = 4096
) (
  input  logic                               in_clk,
  input  logic                               in_rst,
  input  logic                               in_start,
  output logic                               out_busy,
  output logic                               out_done,
  output logic                               out_error,
  output logic                               out_flash_enable,
  output logic                               out_flash_read,
  output logic [WORD_BITS*ADDRESS_WORDS-1:0] out_flash_addr,
  input  logic [WORD_BITS-1:0]               in_flash_data,
  input  logic                               in_flash_word_valid,
  output logic                               out_ram_write,
  output logic [RAM_ADDR_BITS-1:0]           out_ram_addr,
  output logic [WORD_BITS-1:0]               out_ram_data,
  output logic [WORD_BITS-1:0]               out_checksum
);
  localparam int FA_BITS = WORD_BITS * ADDRESS_WORDS;
  localparam int WC_BITS = $clog2(NUM_WORDS) + 1;
  localparam logic [WC_BITS-1:0] LAST_WORD = WC_BITS'(NUM_WORDS - 1);

  t_loader_state      state;
  logic [WC_BITS-1:0] word_ctr;
  logic               start_ok, word_ok, tmr_en, tmr_tc;

  assign start_ok = (state == ST_IDLE) && in_start;
  assign word_ok  = (state == ST_TRANSFER) && in_flash_word_valid;
  // A valid in the terminal cycle keeps tc low, so the word wins over the timeout.
  assign tmr_en   = ((state == ST_REQUEST) || (state == ST_TRANSFER)) && !word_ok;

  timeout_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timer (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .clr    (start_ok || word_ok),
    .en     (tmr_en),
    .tc     (tmr_tc)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state            <= ST_IDLE;
      word_ctr         <= '0;
      out_busy         <= 1'b0;
      out_done         <= 1'b0;
      out_error        <= 1'b0;
      out_flash_enable <= 1'b0;
      out_flash_read   <= 1'b0;
      out_flash_addr   <= '0;
      out_ram_write    <= 1'b0;
      out_ram_addr     <= '0;
      out_ram_data     <= '0;
    end else begin
      out_ram_write  <= 1'b0;
      out_flash_read <= 1'b1;
      case (state)
        ST_IDLE: if (in_start) begin
          state            <= ST_REQUEST;
          word_ctr         <= '0;
          out_busy         <= 1'b1;
          out_done         <= 1'b0;
          out_error        <= 1'b0;
          out_flash_enable <= 1'b1;
          out_flash_addr   <= FA_BITS'(FLASH_START_ADDR);
        end
        ST_REQUEST, ST_TRANSFER: begin
          if (word_ok) begin
            out_ram_write <= 1'b1;
            out_ram_addr  <= RAM_ADDR_BITS'(word_ctr);
            out_ram_data  <= in_flash_data;
            word_ctr      <= word_ctr + 1'b1;
            if (word_ctr == LAST_WORD) begin
              state            <= ST_DONE;
              out_busy         <= 1'b0;
              out_done         <= 1'b1;
              out_flash_enable <= 1'b0;
            end
          end else if (tmr_tc) begin
            state            <= ST_ERROR;
            out_busy         <= 1'b0;
            out_error        <= 1'b1;
            out_flash_enable <= 1'b0;
          end else if (state == ST_REQUEST) begin
            state <= ST_TRANSFER;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  always_ff @(posedge in_clk) begin
    if (!in_rst)       out_checksum <= '0;
    else if (start_ok) out_checksum <= '0;
    else if (word_ok)  out_checksum <= out_checksum + in_flash_data;
  end
`else
  assign out_checksum = '0;
`endif
endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader (NUM_WORDS=4, TIMEOUT_CYCLES=16).
module tb_flash_loader;
`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [15:0] FADDR = 16'h1234;

  logic        in_clk = 1'b0, in_rst = 1'b0, in_start = 1'b0, in_flash_word_valid = 1'b0;
  logic [7:0]  in_flash_data = '0;
  logic        out_busy, out_done, out_error, out_flash_enable, out_flash_read, out_ram_write;
  logic [15:0] out_flash_addr;
  logic [9:0]  out_ram_addr;
  logic [7:0]  out_ram_data, out_checksum;

  flash_loader #(
    .WORD_BITS(8), .ADDRESS_WORDS(2), .RAM_ADDR_BITS(10), .NUM_WORDS(4),
    .FLASH_START_ADDR(32'h1234), .TIMEOUT_CYCLES(16)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start),
    .out_busy(out_busy), .out_done(out_done), .out_error(out_error),
    .out_flash_enable(out_flash_enable), .out_flash_read(out_flash_read),
    .out_flash_addr(out_flash_addr), .in_flash_data(in_flash_data),
    .in_flash_word_valid(in_flash_word_valid), .out_ram_write(out_ram_write),
    .out_ram_addr(out_ram_addr), .out_ram_data(out_ram_data), .out_checksum(out_checksum)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_rises = 0;
  logic done_q = 1'b0;
  logic [9:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];

  // RAM write / done monitor, sampled mid-cycle
  always @(negedge in_clk) begin
    cyc++;
    if (out_ram_write === 1'b1) begin
      wa.push_back(out_ram_addr); wd.push_back(out_ram_data); wc.push_back(cyc);
    end
    if (out_done === 1'b1 && done_q !== 1'b1) done_rises++;
    done_q = out_done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start();
    in_start = 1'b1; tick(); in_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_flash_word_valid = 1'b1; in_flash_data = d; tick();
    in_flash_word_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, out_busy, 0);        chk({tag, "_done"}, out_done, 0);
    chk({tag, "_err"},  out_error, 0);       chk({tag, "_en"},   out_flash_enable, 0);
    chk({tag, "_rd"},   out_flash_read, 0);  chk({tag, "_fa"},   out_flash_addr, 0);
    chk({tag, "_wr"},   out_ram_write, 0);   chk({tag, "_ra"},   out_ram_addr, 0);
    chk({tag, "_rdat"}, out_ram_data, 0);    chk({tag, "_csum"}, out_checksum, 0);
  endtask

  task automatic check_log(input string tag, input int base, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_nwr"}, wa.size() - base, 4);
    for (int i = 0; i < 4 && base + i < wa.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), wa[base+i], i);
      chk($sformatf("%s_d%0d", tag, i), wd[base+i], e[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, dbase, n;
    // Reset state
    idle(3);
    chk_zero("rst");
    in_rst = 1'b1;
    idle(2);

    // 1: spaced valids
    base = wa.size(); dbase = done_rises;
    start();
    chk("t1_busy", out_busy, 1); chk("t1_en", out_flash_enable, 1);
    chk("t1_rd", out_flash_read, 1); chk("t1_fa", out_flash_addr, FADDR);
    idle(9); send(8'h11); idle(9); send(8'h22); idle(9); send(8'h33); idle(9); send(8'h44);
    chk("t1_wr_in_done", out_ram_write, 1); chk("t1_last_addr", out_ram_addr, 3);
    chk("t1_en_low", out_flash_enable, 0); chk("t1_busy_low", out_busy, 0);
    chk("t1_done", out_done, 1);
    tick();
    chk("t1_done_held", out_done, 1); chk("t1_wr_off", out_ram_write, 0);
    check_log("t1", base, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_csum", out_checksum, CSUM ? 8'hAA : 8'h00);
    chk("t1_ndone", done_rises - dbase, 1);

    // 2: back-to-back valids
    base = wa.size();
    start();
    chk("t2_done_clr", out_done, 0); chk("t2_csum_clr", out_checksum, 0);
    idle(2); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("t2_done", out_done, 1);
    tick();
    check_log("t2", base, 8'h05, 8'h06, 8'h07, 8'h08);
    if (wa.size() - base == 4) chk("t2_consec", wc[base+3] - wc[base], 3);
    chk("t2_csum", out_checksum, CSUM ? 8'h1A : 8'h00);

    // 3: timeout after two words
    base = wa.size();
    start();
    idle(2); send(8'h01); send(8'h02);
    n = 0;
    while (out_error !== 1'b1 && n < 40) begin tick(); n++; end
    chk("t3_err_lat", n, 16);
    chk("t3_err", out_error, 1); chk("t3_done", out_done, 0);
    chk("t3_en", out_flash_enable, 0); chk("t3_busy", out_busy, 0);
    tick();
    chk("t3_nwr", wa.size() - base, 2);
    chk("t3_csum", out_checksum, CSUM ? 8'h03 : 8'h00);
    chk("t3_err_held", out_error, 1);

    // 4: start ignored mid-transfer
    base = wa.size(); dbase = done_rises;
    start();
    chk("t4_err_clr", out_error, 0);
    idle(2); send(8'hA0);
    in_start = 1'b1; tick(); in_start = 1'b0;
    chk("t4_busy", out_busy, 1);
    send(8'hA1); send(8'hA2); idle(3); send(8'hA3);
    idle(4);
    check_log("t4", base, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    chk("t4_ndone", done_rises - dbase, 1);
    chk("t4_idle", out_busy, 0);

    // 5: reset mid-burst, then restart
    start();
    idle(1); send(8'h31); send(8'h32);
    in_rst = 1'b0; tick();
    chk_zero("t5_rst");
    in_rst = 1'b1;
    base = wa.size();
    idle(3);
    chk("t5_nwr_after_rst", wa.size() - base, 0);
    start();
    chk("t5_busy", out_busy, 1);
    idle(1); send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    tick();
    check_log("t5", base, 8'h41, 8'h42, 8'h43, 8'h44);

    // 6: valids while idle
    base = wa.size();
    for (int i = 0; i < 3; i++) begin
      send(8'hE0 + 8'(i));
      chk($sformatf("t6_busy%0d", i), out_busy, 0);
      idle(1);
    end
    chk("t6_nwr", wa.size() - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Boot-time copy engine sitting directly upstream of the serial flash controller.
- On a start request it issues one sequential read burst to the flash controller and streams NUM_WORDS received words into a parallel on-chip RAM write port.
- Reports busy, done and error status to the system sequencer.

Parameters:
WORD_BITS, 8, width of one flash/RAM data word
ADDRESS_WORDS, 2, flash address width in words (flash address = WORD_BITS*ADDRESS_WORDS bits)
RAM_ADDR_BITS, 10, RAM address width
NUM_WORDS, 256, words copied per start (1..2**RAM_ADDR_BITS)
FLASH_START_ADDR, 0, first flash byte address read
TIMEOUT_CYCLES, 4096, max in_clk cycles between word_valid pulses before error

Ports:
in_clk  in  1  system clock
in_rst  in  1  reset, synchronous, active-low
in_start  in  1  start request, sampled only in Idle
out_busy  out  1  high from the cycle after start until Done/Error is entered
out_done  out  1  level, high after a successful copy until the next accepted start
out_error  out  1  level, high after a timeout until the next accepted start
out_flash_enable  out  1  flash controller enable, held high for the whole burst
out_flash_read  out  1  read/write select to the flash controller, constant 1
out_flash_addr  out  WORD_BITS*ADDRESS_WORDS  flash start address
in_flash_data  in  WORD_BITS  received data word
in_flash_word_valid  in  1  one-cycle pulse when in_flash_data holds a new data word
out_ram_write  out  1  one-cycle RAM write strobe
out_ram_addr  out  RAM_ADDR_BITS  RAM write address
out_ram_data  out  WORD_BITS  RAM write data
out_checksum  out  WORD_BITS  running checksum (see Optional Feature)

Behaviour:
- Reset (in_rst=0 at a clock edge) values: all outputs 0; state Idle; counters 0.
  - Reset mid-burst drops out_flash_enable at that same edge; no further RAM writes occur.
- States: Idle, Request, Transfer, Done, Error.
- Idle:
  - in_start=1 -> Request next cycle.
  - On that same edge: clear out_done and out_error, zero word_ctr and timeout_ctr, set out_busy=1.
- Request:
  - Drive out_flash_enable=1, out_flash_read=1, out_flash_addr=FLASH_START_ADDR.
  - Go to Transfer unconditionally after one cycle.
- Transfer:
  - out_flash_enable stays 1.
  - On each in_flash_word_valid=1:
    - Next cycle: out_ram_write=1, out_ram_addr=word_ctr, out_ram_data=in_flash_data (1-cycle registered latency).
    - Increment word_ctr and clear timeout_ctr.
  - When the valid that completes word NUM_WORDS-1 is accepted -> Done.
- Timeout:
  - timeout_ctr increments every Request/Transfer cycle without a valid.
  - Reaching TIMEOUT_CYCLES-1 -> Error; that cycle's valid, if present, wins.
- Done:
  - out_flash_enable=0, out_busy=0, out_done=1.
  - The final RAM write strobe still issues in the first Done cycle.
  - Return to Idle next cycle; out_done remains held.
- Error:
  - out_flash_enable=0, out_busy=0, out_error=1; return to Idle next cycle.
  - RAM contents written so far are left as-is.
- in_start while busy is ignored.
- in_flash_word_valid outside Transfer is ignored.
- word_ctr width is $clog2(NUM_WORDS)+1; no wrap. out_ram_addr is the truncated word_ctr.
- Back-to-back valids on consecutive cycles are supported: one write strobe per valid, no drops.

Optional Feature:
- Macro: FLASH_LOADER_CHECKSUM_EN.
- Defined:
  - out_checksum = WORD_BITS-wide modulo-2**WORD_BITS sum of all accepted words.
  - Cleared on accepted start; updated with the same latency as out_ram_data; held after Done/Error.
- Undefined: out_checksum tied to 0; no adder synthesized.

Decomposition:
- Package flash_pkg:
  - flash command constants CMD_READ=8'h03 and CMD_WRITE=8'h02.
  - loader state enum t_loader_state.
  - shared WORD_BITS/ADDRESS_WORDS defaults.
- Sub-module: timeout_timer.
  - Parameterised counter with clear, enable and terminal-count pulse.
  - Reused later by the flash controller's wait timers.

Test Plan:
1. NUM_WORDS=4, start; valids every 10 cycles carrying 11,22,33,44 -> RAM writes addr 0..3 with those data; out_done=1; enable low after the fourth valid; checksum=AA with the macro.
2. Valids on 4 consecutive cycles (5,6,7,8) -> four consecutive write strobes, addr 0..3, no drops.
3. TIMEOUT_CYCLES=16, two valids then silence -> out_error=1 exactly 16 cycles after the last valid; out_done=0; enable low; exactly 2 writes.
4. in_start pulsed again mid-Transfer -> ignored: address sequence is unchanged and there is a single Done.
5. Reset asserted after 2 of 4 words -> all outputs 0 at that edge; a new start restarts at RAM addr 0.
6. Valids pulsed while Idle -> no RAM writes; out_busy stays 0.
